// File: rtl/riscv_defines.sv
// Shared RISC-V front-end types and sizing constants.
package riscv_defines;

    typedef logic [31:0] inst_t;

    // addi x0, x0, 0
    localparam inst_t NOP_INST     = 32'h0000_0013;
    localparam int    FETCHQ_DEPTH = 4;

    // Force a byte address onto a 32-bit word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO with clear; head entry is read straight from the storage registers.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Qualify push/pop: a push into a full FIFO only lands when the head leaves the same cycle.
    always_comb begin
        w_do_pop  = i_pop && (r_count != CW'(0));
        w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);
    end

    // Pointer and occupancy update; clear empties the FIFO regardless of push/pop.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_rd_ptr <= AW'(0);
            r_wr_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end else begin
                r_count <= r_count;
            end
        end
    end

    // Entry storage; contents are don't-care while the FIFO is empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push && !rst && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Status and head outputs.
    always_comb begin
        o_data  = r_mem[r_rd_ptr];
        o_full  = (r_count == CW'(DEPTH));
        o_empty = (r_count == CW'(0));
        o_count = r_count;
    end

endmodule

// File: rtl/fetch_queue.sv
// Prefetch queue: issues sequential word fetches, buffers in-order responses, flushes on redirect.
module fetch_queue
    import riscv_defines::*;
#(
    parameter int          DEPTH    = FETCHQ_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output inst_t       id_inst,
    output logic [31:0] id_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_credit;
    logic          w_full;
    logic          w_empty;
    logic [63:0]   w_head;
    logic          w_req_valid;
    logic          w_accept;
    logic          w_keep;
    logic          w_push;
    logic          w_pop;
    logic          w_id_valid;

    // Credit and handshake decode. Each outstanding request owns a FIFO slot until it returns.
    always_comb begin
        w_credit    = {1'b0, w_count} + {1'b0, r_outstanding};
        w_req_valid = !rst && !redirect_valid && (w_credit < (CW+1)'(DEPTH));
        w_accept    = w_req_valid && imem_req_ready;
        w_keep      = imem_resp_valid && !redirect_valid && (r_discard == CW'(0));
        w_id_valid  = !rst && !w_empty;
        w_pop       = w_id_valid && id_ready;
        w_push      = w_keep && (!w_full || w_pop);
    end

    // Fetch PC, response PC, in-flight and discard bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= CW'(0);
            r_discard     <= CW'(0);
        end else begin
            case ({w_accept, imem_resp_valid})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old stream.
                r_fetch_pc <= word_align(redirect_pc);
                r_resp_pc  <= word_align(redirect_pc);
                r_discard  <= imem_resp_valid ? (r_outstanding - CW'(1)) : r_outstanding;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_keep) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (imem_resp_valid && (r_discard != CW'(0))) begin
                    r_discard <= r_discard - CW'(1);
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({r_resp_pc, imem_resp_data}),
        .i_pop   (w_pop),
        .i_clear (redirect_valid),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Memory and decode-side outputs; decode sees a NOP with PC 0 whenever nothing is valid.
    always_comb begin
        imem_req_valid = w_req_valid;
        imem_req_addr  = r_fetch_pc;
        id_valid       = w_id_valid;
        if (w_id_valid) begin
            id_inst = w_head[31:0];
            id_pc   = w_head[63:32];
        end else begin
            id_inst = NOP_INST;
            id_pc   = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: in-order memory model with configurable latency,
// directed scenarios followed by randomized traffic with redirects and resets.
module tb_fetch_queue;
    import riscv_defines::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    inst_t       id_inst;
    logic [31:0] id_pc;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_inst         (id_inst),
        .id_pc           (id_pc)
    );

    typedef struct { logic [31:0] addr; int due; int epoch; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    req_t        pend[$];      // requests accepted by memory, not yet answered
    ent_t        exp_q[$];     // entries decode must see, in order
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    int          resp_pct = 100;
    int          m_cnt = 0;    // entries held in the queue
    int          m_epoch = 0;  // bumps on every redirect/reset
    logic [31:0] m_fetch = RESET_PC;
    logic [31:0] m_resp_pc = RESET_PC;
    int          accepts = 0;
    ent_t        mon_e;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check the cycle's outputs, advance the reference model.
    task automatic step(input logic r, input logic rv, input logic [31:0] rpc,
                        input logic idr, input logic mrdy);
        req_t e;
        logic take;
        logic exp_req;
        logic keep;
        logic pop;
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = idr;
        imem_req_ready = mrdy;
        take = 1'b0;
        if (!r && pend.size() > 0) begin
            if (pend[0].due <= cyc && $urandom_range(99) < resp_pct) take = 1'b1;
        end
        if (take) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memw(pend[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #2;
        exp_req = !r && !rv && ((m_cnt + pend.size()) < DEPTH);
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
        if (exp_req && imem_req_valid) chk("req_addr", imem_req_addr, m_fetch);
        chk("id_valid", {31'b0, id_valid}, {31'b0, (!r && m_cnt > 0)});
        if (!id_valid) chk("id_inst_nop", id_inst, NOP_INST);
        if (r) chk("id_pc_reset", id_pc, 32'h0);
        if (r) begin
            pend.delete();
            exp_q.delete();
            m_cnt     = 0;
            m_fetch   = RESET_PC;
            m_resp_pc = RESET_PC;
            m_epoch++;
        end else begin
            keep = 1'b0;
            if (take) begin
                e    = pend.pop_front();
                keep = !rv && (e.epoch == m_epoch);
                if (keep) begin
                    exp_q.push_back('{m_resp_pc, memw(m_resp_pc)});
                    m_resp_pc += 32'd4;
                end
            end
            pop = (m_cnt > 0) && idr && !rv;
            if (rv) m_cnt = 0;
            else    m_cnt = m_cnt + int'(keep) - int'(pop);
            if (imem_req_valid && mrdy) begin
                pend.push_back('{imem_req_addr, cyc + lat, m_epoch});
                m_fetch += 32'd4;
                accepts++;
            end
            n_vec++;
            if (m_cnt + pend.size() > DEPTH) begin
                n_err++;
                $display("FAIL credit_overflow: got %0d expected <= %0d (cycle %0d)",
                         m_cnt + pend.size(), DEPTH, cyc);
            end
            if (rv) begin
                m_epoch++;
                m_fetch   = {rpc[31:2], 2'b00};
                m_resp_pc = {rpc[31:2], 2'b00};
                exp_q.delete();
            end
        end
        cyc++;
    endtask

    // Decode-side monitor: every accepted entry must be the next expected one.
    always begin
        @(negedge clk);
        #1;
        if (id_valid === 1'b1 && id_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL id_unexpected: got pc %08h expected no entry", id_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("id_pc", id_pc, mon_e.pc);
                chk("id_inst", id_inst, mon_e.inst);
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int k;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        id_ready = 1'b0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0;

        // Reset, then streaming with single-cycle memory
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (30) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Decode stalled: exactly DEPTH new fetches, then release
        step(1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
        accepts = 0;
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("stall_accepts", accepts, DEPTH);
        repeat (15) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect with three requests in flight at latency 3
        lat = 3;
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
        repeat (20) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect coinciding with a response, then a second redirect
        lat = 2;
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        k = 0;
        while (!(pend.size() > 0 && pend[0].due <= cyc) && k < 10) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            k++;
        end
        step(1'b0, 1'b1, 32'h180, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
        repeat (20) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Address wrap and unaligned redirect target
        lat = 1;
        step(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Reset mid-stream with requests outstanding
        lat = 2;
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (15) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic r;
            logic rv;
            if (i % 100 == 0) begin
                lat      = $urandom_range(4, 1);
                resp_pct = $urandom_range(100, 50);
            end
            r  = ($urandom_range(299) == 0);
            rv = !r && ($urandom_range(39) == 0);
            step(r, rv, $urandom, ($urandom_range(3) != 0), ($urandom_range(3) != 0));
        end

        // Drain: stop fetching and let decode consume everything
        resp_pct = 100;
        k = 0;
        while ((pend.size() > 0 || m_cnt > 0) && k < 200) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            k++;
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_exp_q", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
